sha1_pad: RTL and testbench

Message padder and block loader in front of the SHA-1 round engine. It accepts a big-endian 32-bit word stream and appends the 0x80 marker, zero fill and the 64-bit big-endian bit length. It presents complete 512-bit blocks to the core and holds each block until the round controller signals completion. It drives the core's `valid`, and its `blk_done` input is driven by the core's end-of-rounds pulse (`ready_t`).

---
 rtl/sha1_pkg.sv | 29 ++
 rtl/sha1_len_ctr.sv | 30 +++
 rtl/sha1_pad.sv | 179 +++++++++++++++++
 tb/tb_sha1_pad.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: padder state encoding, padding marker, block geometry.
package sha1_pkg;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_PAD,
      ST_LEN,
      ST_EMIT
   } pad_state_e;

   localparam logic [31:0] SHA1_PAD_MARK = 32'h8000_0000;
   localparam int          SHA1_BLK_W    = 512;
   localparam int          SHA1_LEN_W    = 64;
   localparam logic [4:0]  SHA1_WORDS    = 5'd16;
   localparam logic [4:0]  SHA1_LEN_SLOT = 5'd14;

   // Keep the first 'bytes' bytes of a final word, put 0x80 right after them, zero the rest.
   function automatic logic [31:0] sha1_mark_word(input logic [31:0] data, input logic [1:0] bytes);
      logic [31:0] w;
      case (bytes)
         2'd1:    w = {data[31:24], 24'h80_0000};
         2'd2:    w = {data[31:16], 16'h8000};
         2'd3:    w = {data[31:8],  8'h80};
         default: w = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sha1_len_ctr.sv
// 64-bit message bit-length accumulator; wraps mod 2^64.
module sha1_len_ctr
   import sha1_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clr,
   input  logic                  i_add32,
   input  logic                  i_add_part,
   input  logic [1:0]            i_bytes,
   output logic [SHA1_LEN_W-1:0] o_len
);

   logic [SHA1_LEN_W-1:0] r_len;

   // Accumulate bits per accepted word; a partial final word adds 8 bits per valid byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_len <= '0;
      else if (i_clr)
         r_len <= '0;
      else if (i_add32)
         r_len <= r_len + SHA1_LEN_W'(32);
      else if (i_add_part)
         r_len <= r_len + SHA1_LEN_W'({i_bytes, 3'b000});
   end

   assign o_len = r_len;

endmodule

// File: rtl/sha1_pad.sv
// SHA-1 message padder / block loader. Optional block index output enabled by SHA1_PAD_BLKCNT_EN.
module sha1_pad
   import sha1_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_data,
   input  logic                  in_last,
   input  logic [1:0]            in_bytes,
   output logic                  blk_valid,
   output logic [SHA1_BLK_W-1:0] blk_data,
   output logic                  blk_first,
   output logic                  blk_last,
   input  logic                  blk_done
`ifdef SHA1_PAD_BLKCNT_EN
   ,
   output logic [15:0]           blk_cnt
`endif
);

   pad_state_e            r_state, w_state_nxt;
   logic [3:0]            r_w, w_w_nxt;
   logic                  r_mark, w_mark_nxt;
   logic                  r_padp, w_padp_nxt;
   logic                  r_first, w_first_nxt;
   logic                  r_last, w_last_nxt;
   logic [SHA1_BLK_W-1:0] r_blk;
   logic [4:0]            w_w_inc;
   logic                  w_we, w_len_we, w_add32, w_add_part, w_clr;
   logic [31:0]           w_wval;
   logic [SHA1_LEN_W-1:0] w_len;

   assign w_w_inc = {1'b0, r_w} + 5'd1;

   sha1_len_ctr u_len (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_clr),
      .i_add32    (w_add32),
      .i_add_part (w_add_part),
      .i_bytes    (in_bytes),
      .o_len      (w_len)
   );

   // Control registers: state, slot pointer, pending marker, padding-in-progress, first/last flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FILL;
         r_w     <= '0;
         r_mark  <= 1'b0;
         r_padp  <= 1'b0;
         r_first <= 1'b1;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_w     <= w_w_nxt;
         r_mark  <= w_mark_nxt;
         r_padp  <= w_padp_nxt;
         r_first <= w_first_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Next-state and slot-write decode; the pointer wraps to 0 when a block fills (slot 16 == next block's 0).
   always_comb begin
      w_state_nxt = r_state;
      w_w_nxt     = r_w;
      w_mark_nxt  = r_mark;
      w_padp_nxt  = r_padp;
      w_first_nxt = r_first;
      w_last_nxt  = r_last;
      w_we        = 1'b0;
      w_wval      = in_data;
      w_len_we    = 1'b0;
      w_add32     = 1'b0;
      w_add_part  = 1'b0;
      w_clr       = 1'b0;
      unique case (r_state)
         ST_FILL: begin
            if (in_valid) begin
               w_we    = 1'b1;
               w_w_nxt = w_w_inc[3:0];
               if (in_last) begin
                  w_padp_nxt = 1'b1;
                  if (in_bytes == 2'd0) begin
                     w_add32    = 1'b1;
                     w_mark_nxt = 1'b1;
                  end else begin
                     w_add_part = 1'b1;
                     w_wval     = sha1_mark_word(in_data, in_bytes);
                  end
                  if (w_w_inc == SHA1_WORDS) begin
                     w_state_nxt = ST_EMIT;
                     w_last_nxt  = 1'b0;
                  end else if (w_w_inc == SHA1_LEN_SLOT && in_bytes != 2'd0)
                     w_state_nxt = ST_LEN;
                  else
                     w_state_nxt = ST_PAD;
               end else begin
                  w_add32 = 1'b1;
                  if (w_w_inc == SHA1_WORDS) begin
                     w_state_nxt = ST_EMIT;
                     w_last_nxt  = 1'b0;
                     w_padp_nxt  = 1'b0;
                  end
               end
            end
         end
         ST_PAD: begin
            w_we       = 1'b1;
            w_wval     = r_mark ? SHA1_PAD_MARK : 32'd0;
            w_mark_nxt = 1'b0;
            w_w_nxt    = w_w_inc[3:0];
            if (w_w_inc == SHA1_WORDS) begin
               w_state_nxt = ST_EMIT;
               w_last_nxt  = 1'b0;
            end else if (w_w_inc == SHA1_LEN_SLOT)
               w_state_nxt = ST_LEN;
         end
         ST_LEN: begin
            w_len_we    = 1'b1;
            w_state_nxt = ST_EMIT;
            w_last_nxt  = 1'b1;
            w_padp_nxt  = 1'b0;
         end
         ST_EMIT: begin
            if (blk_done) begin
               w_w_nxt     = '0;
               w_first_nxt = 1'b0;
               if (r_last) begin
                  w_state_nxt = ST_FILL;
                  w_first_nxt = 1'b1;
                  w_last_nxt  = 1'b0;
                  w_clr       = 1'b1;
               end else if (r_padp)
                  w_state_nxt = ST_PAD;
               else
                  w_state_nxt = ST_FILL;
            end
         end
         default: w_state_nxt = ST_FILL;
      endcase
   end

   // Block buffer: one word slot per cycle; LEN writes the 64-bit length into slots 14/15.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_blk <= '0;
      else begin
         if (w_we)
            r_blk[{~r_w, 5'd0} +: 32] <= w_wval;
         if (w_len_we)
            r_blk[SHA1_LEN_W-1:0] <= w_len;
      end
   end

   assign in_ready  = (r_state == ST_FILL);
   assign blk_valid = (r_state == ST_EMIT);
   assign blk_data  = r_blk;
   assign blk_first = r_first;
   assign blk_last  = r_last;

`ifdef SHA1_PAD_BLKCNT_EN
   logic [15:0] r_cnt;

   // Block index within the message: counts completed blocks, saturates, restarts per message.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (r_state == ST_EMIT && blk_done)
         r_cnt <= r_last ? 16'd0 : ((r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1);
   end

   assign blk_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_sha1_pad.sv
// Directed bench for sha1_pad (also exercises blk_cnt when SHA1_PAD_BLKCNT_EN is defined).
module tb_sha1_pad;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_last;
   logic [1:0]   in_bytes;
   logic         blk_valid;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;
   logic         blk_done;
`ifdef SHA1_PAD_BLKCNT_EN
   logic [15:0]  blk_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   sha1_pad dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .blk_valid (blk_valid),
      .blk_data  (blk_data),
      .blk_first (blk_first),
      .blk_last  (blk_last),
      .blk_done  (blk_done)
`ifdef SHA1_PAD_BLKCNT_EN
      ,
      .blk_cnt   (blk_cnt)
`endif
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  bytes;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w15;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   function automatic logic [511:0] put(input logic [511:0] b, input int idx, input logic [31:0] v);
      logic [511:0] r;
      r = b;
      r[(15 - idx) * 32 +: 32] = v;
      return r;
   endfunction

   // Present one word and hold it until it is accepted; returns at the negedge before the accepting posedge.
   task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_bytes = nb;
      t = 0;
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_total++;
         $display("FAIL send_word_timeout: in_ready stayed %0d, required 1", in_ready);
      end
   endtask

   task automatic wait_valid(input string nm, output int cyc);
      cyc = 0;
      while (!blk_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (!blk_valid) begin
         n_total++;
         $display("FAIL %s_timeout: blk_valid=%0d after %0d cycles, required 1", nm, blk_valid, cyc);
      end
   endtask

   task automatic done_pulse();
      blk_done = 1'b1;
      @(negedge clk);
      blk_done = 1'b0;
   endtask

   initial begin
      logic [511:0] exp;
      logic [511:0] snap;
      int           cyc;
      int           bad;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      in_bytes = 2'd0;
      blk_done = 1'b0;

      vecs[0] = '{data: 32'h6162_6300, bytes: 2'd3, w0: 32'h6162_6380, w1: 32'h0,         w15: 32'h18};
      vecs[1] = '{data: 32'h41FF_FFFF, bytes: 2'd1, w0: 32'h4180_0000, w1: 32'h0,         w15: 32'h08};
      vecs[2] = '{data: 32'h4142_EEEE, bytes: 2'd2, w0: 32'h4142_8000, w1: 32'h0,         w15: 32'h10};
      vecs[3] = '{data: 32'h4142_4344, bytes: 2'd0, w0: 32'h4142_4344, w1: 32'h8000_0000, w15: 32'h20};

      repeat (3) @(negedge clk);
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_blk_valid", blk_valid, 0);
      chk("rst_blk_first", blk_first, 1);
      chk("rst_blk_last",  blk_last,  0);
      chk("rst_blk_data",  blk_data,  0);
      rst_n = 1'b1;

      // Single-word messages: latency, padded block, flags.
      for (int i = 0; i < 4; i++) begin
         send_word(vecs[i].data, 1'b1, vecs[i].bytes);
         @(negedge clk);
         in_valid = 1'b0;
         cyc = 1;
         while (!blk_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         chk($sformatf("v%0d_latency", i), cyc, 15);
         chk($sformatf("v%0d_block", i), blk_data, {vecs[i].w0, vecs[i].w1, 416'd0, vecs[i].w15});
         chk($sformatf("v%0d_first", i), blk_first, 1);
         chk($sformatf("v%0d_last", i), blk_last, 1);
`ifdef SHA1_PAD_BLKCNT_EN
         chk($sformatf("v%0d_cnt", i), blk_cnt, 0);
`endif
         done_pulse();
         chk($sformatf("v%0d_valid_clr", i), blk_valid, 0);
         chk($sformatf("v%0d_ready_back", i), in_ready, 1);
      end

      // 56-byte message: marker spills to slot 14, length goes in a second block.
      for (int i = 0; i < 14; i++)
         send_word(32'hC0DE_0000 | 32'(i), i == 13, 2'd0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid("m14_b1", cyc);
      exp = '0;
      for (int i = 0; i < 14; i++)
         exp = put(exp, i, 32'hC0DE_0000 | 32'(i));
      exp = put(exp, 14, 32'h8000_0000);
      chk("m14_b1_block", blk_data, exp);
      chk("m14_b1_first", blk_first, 1);
      chk("m14_b1_last", blk_last, 0);
      done_pulse();
      chk("m14_pad_ready", in_ready, 0);
      wait_valid("m14_b2", cyc);
      chk("m14_b2_block", blk_data, {480'd0, 32'h0000_01C0});
      chk("m14_b2_first", blk_first, 0);
      chk("m14_b2_last", blk_last, 1);
      done_pulse();

      // 64-byte message: block emitted immediately, marker opens the next block.
      for (int i = 0; i < 16; i++)
         send_word(32'h5A00_0000 | 32'(i), i == 15, 2'd0);
      @(negedge clk);
      chk("m16_emit_now", blk_valid, 1);
      in_valid = 1'b0;
      exp = '0;
      for (int i = 0; i < 16; i++)
         exp = put(exp, i, 32'h5A00_0000 | 32'(i));
      chk("m16_b1_block", blk_data, exp);
      chk("m16_b1_last", blk_last, 0);
`ifdef SHA1_PAD_BLKCNT_EN
      chk("m16_b1_cnt", blk_cnt, 0);
`endif
      done_pulse();
      wait_valid("m16_b2", cyc);
      chk("m16_b2_block", blk_data, {32'h8000_0000, 448'd0, 32'h0000_0200});
      chk("m16_b2_first", blk_first, 0);
      chk("m16_b2_last", blk_last, 1);
`ifdef SHA1_PAD_BLKCNT_EN
      chk("m16_b2_cnt", blk_cnt, 1);
`endif
      done_pulse();
`ifdef SHA1_PAD_BLKCNT_EN
      chk("m16_cnt_clr", blk_cnt, 0);
`endif

      // 20-word message with in_valid held through a 100-cycle EMIT stall.
      for (int i = 0; i < 16; i++)
         send_word(32'hA500_0000 | 32'(i), 1'b0, 2'd0);
      @(negedge clk);
      chk("stall_emit_now", blk_valid, 1);
      in_data = 32'hA500_0010;
      snap = blk_data;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (in_ready !== 1'b0 || blk_data !== snap || blk_valid !== 1'b1)
            bad++;
      end
      chk("stall_stable", bad, 0);
      exp = '0;
      for (int i = 0; i < 16; i++)
         exp = put(exp, i, 32'hA500_0000 | 32'(i));
      chk("stall_b1_block", blk_data, exp);
      chk("stall_ready_at_done", in_ready, 0);
      done_pulse();
      chk("stall_ready_after_done", in_ready, 1);
      for (int i = 17; i < 20; i++)
         send_word(32'hA500_0000 | 32'(i), i == 19, 2'd0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid("stall_b2", cyc);
      exp = '0;
      for (int i = 0; i < 4; i++)
         exp = put(exp, i, 32'hA500_0010 | 32'(i));
      exp = put(exp, 4, 32'h8000_0000);
      exp = put(exp, 15, 32'h0000_0280);
      chk("stall_b2_block", blk_data, exp);
      chk("stall_b2_last", blk_last, 1);
      done_pulse();

      // Reset in the middle of a message discards it.
      for (int i = 0; i < 7; i++)
         send_word(32'h7700_0000 | 32'(i), 1'b0, 2'd0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", blk_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_data", blk_data, 0);
      rst_n = 1'b1;
      send_word(32'h6162_6300, 1'b1, 2'd3);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid("post_rst", cyc);
      chk("post_rst_block", blk_data, {32'h6162_6380, 448'd0, 32'h18});
      chk("post_rst_first", blk_first, 1);
      chk("post_rst_last", blk_last, 1);
      done_pulse();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
